mb_drive_xfer: RTL and testbench

- Drive-side (Massbus slave) data-transfer engine. Sits behind one drive's port of the massbus slave modport.
- Executes read data, write data and write check functions for one unit.
- Moves 36-bit words between the RH11 (over the mbREQO/mbACKI handshake) and a local 128-word sector buffer.
- Sector buffer fill/flush is delegated to an external sector controller (SD side) through a request/acknowledge pair.

---
 rtl/mb_drive_xfer.sv | 192 +++++++++++++++++++
 tb/tb_mb_drive_xfer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_drive_xfer.sv
// Massbus drive-side transfer engine: read, write and write-check between the RH11 and a sector buffer.
// Optional REQ/ACK watchdog enabled by defining MB_DRIVE_XFER_TIMEOUT_EN.
module mb_drive_xfer #(
  parameter int DRVNUM  = 0,
  parameter int WPS     = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mbINIT,
  input  logic        mbGO,
  input  logic [4:0]  mbFUN,
  input  logic [2:0]  mbUNIT,
  input  logic        mbWCZ,
  input  logic        mbACKI,
  input  logic [35:0] mbDATAI,
  output logic        mbREQO,
  output logic [35:0] mbDATAO,
  output logic        mbINCBA,
  output logic        mbINCWC,
  output logic        mbWCE,
  output logic        mbNPRO,
  output logic        mbATA,
  output logic        secREQ,
  output logic        secWR,
  input  logic        secACK,
  output logic [6:0]  bufADDR,
  input  logic [35:0] bufDI,
  output logic [35:0] bufDO,
  output logic        bufWE,
  output logic        xferBUSY,
  output logic        xferERR
);

  typedef enum logic [2:0] {IDLE, FILL, FETCH, REQ, INC, CHK, FLUSH, DONE} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_WCHK} op_t;

  localparam logic [4:0] FUN_READ  = 5'o34;
  localparam logic [4:0] FUN_WRITE = 5'o30;
  localparam logic [4:0] FUN_WCHK  = 5'o24;
  localparam logic [6:0] IDX_MASK  = 7'(WPS - 1);

  if (WPS < 2 || WPS > 128 || (WPS & (WPS - 1)) != 0) begin : gBadWps
    $error("mb_drive_xfer: WPS must be a power of two in 2..128");
  end
  if (TIMEOUT < 1) begin : gBadTimeout
    $error("mb_drive_xfer: TIMEOUT must be at least 1");
  end

  state_t     state, nxt;
  op_t        op, funOp;
  logic [6:0] index;
  logic       fetchHold;
  logic       lastFlush;
  logic       funValid;
  logic       goOk;
  logic       wcMiss;
  logic       toHit;

  always_comb begin
    funValid = 1'b1;
    funOp    = OP_READ;
    case (mbFUN)
      FUN_READ:  funOp = OP_READ;
      FUN_WRITE: funOp = OP_WRITE;
      FUN_WCHK:  funOp = OP_WCHK;
      default:   funValid = 1'b0;
    endcase
  end

  assign goOk     = mbGO && funValid && (mbUNIT == 3'(DRVNUM));
  assign wcMiss   = (state == REQ) && mbACKI && (op == OP_WCHK) && (mbDATAI != mbDATAO);
  assign bufADDR  = index;
  assign bufDO    = mbDATAI;
  assign xferBUSY = (state != IDLE);

`ifdef MB_DRIVE_XFER_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0] toCnt;

  always_ff @(posedge clk) begin
    if (rst || mbINIT) begin
      toCnt <= '0;
    end else if (state == REQ && !mbACKI) begin
      toCnt <= toCnt + 1'b1;
    end else begin
      toCnt <= '0;
    end
  end

  // REQ is held for exactly TIMEOUT cycles before giving up
  assign toHit = (state == REQ) && !mbACKI && (toCnt == TOW'(TIMEOUT - 1));
`else
  assign toHit = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    mbREQO  = 1'b0;
    mbNPRO  = 1'b0;
    mbINCBA = 1'b0;
    mbINCWC = 1'b0;
    mbWCE   = 1'b0;
    secREQ  = 1'b0;
    secWR   = 1'b0;
    bufWE   = 1'b0;
    case (state)
      IDLE: begin
        if (goOk) nxt = (funOp == OP_WRITE) ? REQ : FILL;
      end
      FILL: begin
        secREQ = 1'b1;
        if (secACK) nxt = FETCH;
      end
      FETCH: begin
        mbNPRO = 1'b1;
        if (fetchHold) nxt = REQ;
      end
      REQ: begin
        mbNPRO = 1'b1;
        mbREQO = 1'b1;
        if (mbACKI) begin
          bufWE = (op == OP_WRITE);
          if (wcMiss) begin
            mbWCE = 1'b1;
            nxt   = DONE;
          end else begin
            nxt = INC;
          end
        end else if (toHit) begin
          nxt = DONE;
        end
      end
      INC: begin
        mbNPRO  = 1'b1;
        mbINCBA = 1'b1;
        mbINCWC = 1'b1;
        nxt     = CHK;
      end
      CHK: begin
        if (mbWCZ)            nxt = (op == OP_WRITE) ? FLUSH : DONE;
        else if (index == '0) nxt = (op == OP_WRITE) ? FLUSH : FILL;
        else                  nxt = (op == OP_WRITE) ? REQ : FETCH;
      end
      FLUSH: begin
        secREQ = 1'b1;
        secWR  = 1'b1;
        if (secACK) nxt = lastFlush ? DONE : REQ;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || mbINIT) begin
      state     <= IDLE;
      op        <= OP_READ;
      index     <= '0;
      fetchHold <= 1'b0;
      lastFlush <= 1'b0;
      mbDATAO   <= '0;
      mbATA     <= 1'b0;
      xferERR   <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (goOk) begin
            op        <= funOp;
            index     <= '0;
            fetchHold <= 1'b0;
            lastFlush <= 1'b0;
            xferERR   <= 1'b0;
            mbATA     <= 1'b0;
          end
        end
        // first FETCH cycle presents the address, second captures the buffer output
        FETCH: begin
          fetchHold <= !fetchHold;
          if (fetchHold) mbDATAO <= bufDI;
        end
        REQ:  if (wcMiss || toHit) xferERR <= 1'b1;
        INC:  index <= (index + 7'd1) & IDX_MASK;
        CHK:  lastFlush <= mbWCZ;
        DONE: mbATA <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_drive_xfer.sv
// Scoreboard bench for mb_drive_xfer with RH11, sector controller and buffer RAM models.
module tb_mb_drive_xfer;

  logic        clk = 1'b0;
  logic        rst, mbINIT, mbGO, mbWCZ, mbACKI, secACK;
  logic [4:0]  mbFUN;
  logic [2:0]  mbUNIT;
  logic [35:0] mbDATAI, mbDATAO, bufDI, bufDO;
  logic        mbREQO, mbINCBA, mbINCWC, mbWCE, mbNPRO, mbATA;
  logic        secREQ, secWR, bufWE, xferBUSY, xferERR;
  logic [6:0]  bufADDR;

  always #5 clk = ~clk;

  mb_drive_xfer #(.DRVNUM(0), .WPS(128), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .mbINIT(mbINIT), .mbGO(mbGO), .mbFUN(mbFUN), .mbUNIT(mbUNIT),
    .mbWCZ(mbWCZ), .mbACKI(mbACKI), .mbDATAI(mbDATAI), .mbREQO(mbREQO), .mbDATAO(mbDATAO),
    .mbINCBA(mbINCBA), .mbINCWC(mbINCWC), .mbWCE(mbWCE), .mbNPRO(mbNPRO), .mbATA(mbATA),
    .secREQ(secREQ), .secWR(secWR), .secACK(secACK), .bufADDR(bufADDR), .bufDI(bufDI),
    .bufDO(bufDO), .bufWE(bufWE), .xferBUSY(xferBUSY), .xferERR(xferERR)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // buffer RAM with one-cycle read latency; bench preload port has priority
  logic [35:0] mem [128];
  logic        pWe = 1'b0;
  logic [6:0]  pAddr = '0;
  logic [35:0] pData = '0;
  always @(posedge clk) begin
    bufDI <= mem[bufADDR];
    if (pWe) mem[pAddr] <= pData;
    else if (bufWE) mem[bufADDR] <= bufDO;
  end

  // RH11 model: acknowledges each request one cycle after it appears
  int          ackTotal = 0;
  int          ackStop  = 0;
  int          dataOff  = 0;
  logic [35:0] dataBase = '0;
  initial begin
    mbACKI  = 1'b0;
    mbDATAI = '0;
    forever begin
      @(posedge clk); #1;
      if (mbACKI) mbACKI = 1'b0;
      else if (mbREQO && ackTotal < ackStop) begin
        mbACKI  = 1'b1;
        mbDATAI = dataBase + 36'(ackTotal - dataOff);
        ackTotal++;
      end
    end
  end

  // sector controller model: acknowledges after three cycles of request
  int sCnt = 0;
  initial begin
    secACK = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (secACK) begin
        secACK = 1'b0;
        sCnt   = 0;
      end else if (secREQ) begin
        sCnt++;
        if (sCnt == 3) secACK = 1'b1;
      end else sCnt = 0;
    end
  end

  typedef struct {logic [6:0] a; logic [35:0] d;} wr_t;
  wr_t         wrQ[$];
  logic [35:0] rdQ[$];
  logic        checkRd = 1'b0;
  int          incba = 0, incwc = 0, wce = 0, secWrReqs = 0, secRdReqs = 0;
  int          wczAt = 0;
  logic        prevSecReq = 1'b0;

  assign mbWCZ = (incwc >= wczAt);

  // monitor: pops expected values whenever the DUT presents a word or a buffer write
  initial begin
    forever begin
      @(negedge clk);
      if (mbREQO && mbACKI && checkRd) begin
        if (rdQ.size() == 0) check("rd_unexpected", 64'(mbDATAO), 64'h1_0000_0000_0);
        else check("rd_data", 64'(mbDATAO), 64'(rdQ.pop_front()));
      end
      if (bufWE) begin
        if (wrQ.size() == 0) check("wr_unexpected", {21'd0, bufADDR, bufDO}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          wr_t e;
          e = wrQ.pop_front();
          check("wr_word", {21'd0, bufADDR, bufDO}, {21'd0, e.a, e.d});
        end
      end
      if (mbINCBA) incba++;
      if (mbINCWC) incwc++;
      if (mbWCE) wce++;
      if (secREQ && !prevSecReq) begin
        if (secWR) secWrReqs++;
        else secRdReqs++;
      end
      prevSecReq = secREQ;
    end
  end

  task automatic go(input logic [4:0] fun, input logic [2:0] unit);
    @(posedge clk); #1;
    mbGO = 1'b1; mbFUN = fun; mbUNIT = unit;
    @(posedge clk); #1;
    mbGO = 1'b0; mbFUN = '0; mbUNIT = '0;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int c;
    c = 0;
    while (xferBUSY && c < maxCycles) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, 64'(xferBUSY), 64'd0);
  endtask

  task automatic preload(input int mode);
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1;
      pWe   = 1'b1;
      pAddr = 7'(i);
      if (mode == 0) pData = 36'(i);
      else pData = (i == 1) ? 36'o123 : 36'o5000 + 36'(i);
    end
    @(posedge clk); #1;
    pWe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int a0, b0, w0, e0, f0, r0, n;
  logic saw;

  initial begin
    rst = 1'b1; mbINIT = 1'b0; mbGO = 1'b0; mbFUN = '0; mbUNIT = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ctrl", {50'd0, mbREQO, mbINCBA, mbINCWC, mbWCE, mbNPRO, mbATA, secREQ, secWR,
                         bufWE, xferBUSY, xferERR, 3'd0}, 64'd0);
    check("reset_addr", 64'(bufADDR), 64'd0);
    check("reset_datao", 64'(mbDATAO), 64'd0);

    // read: three words, word count reaches zero after the third increment
    preload(0);
    checkRd = 1'b1;
    rdQ.push_back(36'd0); rdQ.push_back(36'd1); rdQ.push_back(36'd2);
    a0 = ackTotal; b0 = incba; w0 = incwc; r0 = secRdReqs;
    wczAt = incwc + 3; ackStop = ackTotal + 10; dataOff = ackTotal; dataBase = '0;
    go(5'o34, 3'd0);
    waitIdle("rd_idle", 500);
    checkRd = 1'b0;
    check("rd_acks", 64'(ackTotal - a0), 64'd3);
    check("rd_queue_empty", 64'(rdQ.size()), 64'd0);
    check("rd_incba", 64'(incba - b0), 64'd3);
    check("rd_incwc", 64'(incwc - w0), 64'd3);
    check("rd_fills", 64'(secRdReqs - r0), 64'd1);
    check("rd_ata", 64'(mbATA), 64'd1);
    check("rd_err", 64'(xferERR), 64'd0);

    // foreign unit and unknown function must be ignored
    ackStop = ackTotal;
    saw = 1'b0;
    go(5'o34, 3'd3);
    saw = saw | xferBUSY | secREQ | mbREQO;
    go(5'o01, 3'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw = saw | xferBUSY | secREQ | mbREQO;
    end
    check("ign_activity", 64'(saw), 64'd0);
    check("ign_ata_kept", 64'(mbATA), 64'd1);

    // write: 130 words, wrap flush then partial-sector flush
    for (int i = 0; i < 130; i++) begin
      wr_t e;
      e.a = 7'(i % 128);
      e.d = 36'o777000000000 + 36'(i);
      wrQ.push_back(e);
    end
    a0 = ackTotal; w0 = incwc; f0 = secWrReqs;
    wczAt = incwc + 130; ackStop = ackTotal + 130; dataOff = ackTotal; dataBase = 36'o777000000000;
    go(5'o30, 3'd0);
    check("wr_ata_cleared", 64'(mbATA), 64'd0);
    waitIdle("wr_idle", 3000);
    check("wr_acks", 64'(ackTotal - a0), 64'd130);
    check("wr_queue_empty", 64'(wrQ.size()), 64'd0);
    check("wr_flushes", 64'(secWrReqs - f0), 64'd2);
    check("wr_incwc", 64'(incwc - w0), 64'd130);
    check("wr_mem0", 64'(mem[0]), 64'(36'o777000000200));
    check("wr_mem2_stale", 64'(mem[2]), 64'(36'o777000000002));
    check("wr_ata", 64'(mbATA), 64'd1);

    // write check: second word mismatches
    preload(1);
    checkRd = 1'b1;
    rdQ.push_back(36'o5000); rdQ.push_back(36'o123);
    a0 = ackTotal; w0 = incwc; e0 = wce;
    wczAt = incwc + 10; ackStop = ackTotal + 10; dataOff = ackTotal; dataBase = 36'o5000;
    go(5'o24, 3'd0);
    waitIdle("wc_idle", 500);
    checkRd = 1'b0;
    check("wc_acks", 64'(ackTotal - a0), 64'd2);
    check("wc_wce", 64'(wce - e0), 64'd1);
    check("wc_incwc", 64'(incwc - w0), 64'd1);
    check("wc_err", 64'(xferERR), 64'd1);
    check("wc_ata", 64'(mbATA), 64'd1);
    check("wc_queue_empty", 64'(rdQ.size()), 64'd0);

    // mbINIT while waiting in REQ at index 2, then restart
    wrQ.push_back('{7'd0, 36'o1000}); wrQ.push_back('{7'd1, 36'o1001});
    wczAt = incwc + 100; ackStop = ackTotal + 2; dataOff = ackTotal; dataBase = 36'o1000;
    go(5'o30, 3'd0);
    check("init_err_cleared", 64'(xferERR), 64'd0);
    n = 0;
    while (!(mbREQO && !mbACKI && ackTotal >= ackStop) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_reach_req", 64'(mbREQO), 64'd1);
    mbINIT = 1'b1;
    @(posedge clk); #1;
    mbINIT = 1'b0;
    check("init_ctrl", {50'd0, mbREQO, mbINCBA, mbINCWC, mbWCE, mbNPRO, mbATA, secREQ, secWR,
                        bufWE, xferBUSY, xferERR, 3'd0}, 64'd0);
    check("init_addr", 64'(bufADDR), 64'd0);
    check("init_datao", 64'(mbDATAO), 64'd0);
    wrQ.push_back('{7'd0, 36'o2000});
    f0 = secWrReqs;
    wczAt = incwc + 1; ackStop = ackTotal + 1; dataOff = ackTotal; dataBase = 36'o2000;
    go(5'o30, 3'd0);
    waitIdle("restart_idle", 500);
    check("restart_queue_empty", 64'(wrQ.size()), 64'd0);
    check("restart_flush", 64'(secWrReqs - f0), 64'd1);
    check("restart_ata", 64'(mbATA), 64'd1);

`ifdef MB_DRIVE_XFER_TIMEOUT_EN
    // ACK withheld: REQ held for TIMEOUT cycles then error
    b0 = incba; w0 = incwc;
    wczAt = incwc + 100; ackStop = ackTotal;
    go(5'o30, 3'd0);
    n = 0;
    while (mbREQO && n < 100) begin
      @(negedge clk);
      if (mbREQO) n++;
    end
    check("to_req_cycles", 64'(n), 64'd16);
    waitIdle("to_idle", 50);
    check("to_err", 64'(xferERR), 64'd1);
    check("to_ata", 64'(mbATA), 64'd1);
    check("to_incba", 64'(incba - b0), 64'd0);
    check("to_incwc", 64'(incwc - w0), 64'd0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
